// File: rtl/traffic_phase_ctrl_if.sv
// Mode/request inputs and lamp outputs of traffic_phase_ctrl.
// The controller takes the slave side; whoever drives the modes and requests takes the master side.
interface traffic_phase_ctrl_if #(
    parameter int NUM_PHASES = 2
);
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                  FM;
    logic                  TEST;
    logic [NUM_PHASES-1:0] DEMAND;
    logic [NUM_PHASES-1:0] GRN;
    logic [NUM_PHASES-1:0] YLW;
    logic [NUM_PHASES-1:0] RED;
    logic [PW-1:0]         PHASE;

    modport master (
        output FM, TEST, DEMAND,
        input  GRN, YLW, RED, PHASE
    );

    modport slave (
        input  FM, TEST, DEMAND,
        output GRN, YLW, RED, PHASE
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach traffic-light sequencer: GREEN -> YELLOW -> ALL-RED per
// approach, shared prescaled interval timer, farm-mode demand skipping.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES   = 2,
    parameter int TW           = 8,
    parameter int GREEN_TICKS  = 40,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int PRESCALE     = 16
) (
    input  logic                CK,
    input  logic                CLRN,
    traffic_phase_ctrl_if.slave ctrl_io
);
    localparam int PW  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int PSW = $clog2(PRESCALE);

    localparam logic [TW-1:0]  G_LD    = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0]  Y_LD    = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0]  A_LD    = TW'(ALLRED_TICKS - 1);
    localparam logic [PSW-1:0] P_TOP   = PSW'(PRESCALE - 1);
    localparam logic [PW-1:0]  PH_LAST = PW'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [PSW-1:0]        pre_q, pre_d;
    logic [NUM_PHASES-1:0] dem_q, dem_d;
    logic [NUM_PHASES-1:0] grn_q, grn_d;
    logic [NUM_PHASES-1:0] ylw_q, ylw_d;

    logic                  tick;
    logic                  expiry;
    logic                  other_dem;
    logic [NUM_PHASES-1:0] cur_oh;
    logic [NUM_PHASES-1:0] nxt_oh;
    logic [NUM_PHASES-1:0] clr;
    logic [PW-1:0]         nxt_phase;
    int                    best_c;
    int                    dist_c;
    int                    tgt_c;

    // Prescaler: TEST forces a tick every cycle and parks the count at 0
    always_comb begin
        tick  = 1'b0;
        pre_d = pre_q;
        if (ctrl_io.TEST) begin
            tick  = 1'b1;
            pre_d = '0;
        end else if (pre_q == P_TOP) begin
            tick  = 1'b1;
            pre_d = '0;
        end else begin
            pre_d = pre_q + PSW'(1);
        end
    end

    assign expiry    = tick && (timer_q == '0);
    assign cur_oh    = NUM_PHASES'(1) << phase_q;
    assign other_dem = |(dem_q & ~cur_oh);

    // Nearest cyclic successor with latched demand; distance N means self
    always_comb begin
        best_c = 1;
        dist_c = 0;
        if (ctrl_io.FM) begin
            best_c = NUM_PHASES + 1;
            for (int j = NUM_PHASES - 1; j >= 0; j--) begin
                dist_c = j - int'(phase_q);
                if (dist_c <= 0) dist_c = dist_c + NUM_PHASES;
                if (dem_q[j] && dist_c < best_c) best_c = dist_c;
            end
            if (best_c > NUM_PHASES) best_c = 1;
        end
        tgt_c = int'(phase_q) + best_c;
        if (tgt_c >= NUM_PHASES) tgt_c = tgt_c - NUM_PHASES;
        nxt_phase = PW'(tgt_c);
    end

    assign nxt_oh = NUM_PHASES'(1) << nxt_phase;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        clr     = '0;
        if (tick) timer_d = timer_q - TW'(1);
        if (expiry) begin
            unique case (state_q)
                S_ALLRED: begin
                    state_d = S_GREEN;
                    phase_d = nxt_phase;
                    timer_d = G_LD;
                    clr     = nxt_oh;
                end
                S_GREEN: begin
                    if (ctrl_io.FM && !other_dem) begin
                        timer_d = G_LD;
                    end else begin
                        state_d = S_YELLOW;
                        timer_d = Y_LD;
                    end
                end
                S_YELLOW: begin
                    state_d = S_ALLRED;
                    timer_d = A_LD;
                end
                default: begin
                    state_d = S_ALLRED;
                    timer_d = A_LD;
                end
            endcase
        end
    end

    // Clear beats a coinciding request, but only for the approach going green
    assign dem_d = (dem_q | ctrl_io.DEMAND) & ~clr;

    always_comb begin
        grn_d = '0;
        ylw_d = '0;
        unique case (state_d)
            S_GREEN:  grn_d = NUM_PHASES'(1) << phase_d;
            S_YELLOW: ylw_d = NUM_PHASES'(1) << phase_d;
            default: ;
        endcase
    end

    always_ff @(posedge CK or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= S_ALLRED;
            phase_q <= PH_LAST;
            timer_q <= A_LD;
            pre_q   <= '0;
            dem_q   <= '0;
            grn_q   <= '0;
            ylw_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            pre_q   <= pre_d;
            dem_q   <= dem_d;
            grn_q   <= grn_d;
            ylw_q   <= ylw_d;
        end
    end

    assign ctrl_io.GRN   = grn_q;
    assign ctrl_io.YLW   = ylw_q;
    assign ctrl_io.RED   = ~(grn_q | ylw_q);
    assign ctrl_io.PHASE = phase_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: N=2 defaults, N=3 farm mode,
// and a one-tick-per-state instance, with per-cycle lamp invariant monitors.
module tb_traffic_phase_ctrl;
    logic CK;
    logic rst2, rst3, rst1;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial CK = 1'b0;
    always #5 CK = ~CK;

    traffic_phase_ctrl_if #(.NUM_PHASES(2)) if2 ();
    traffic_phase_ctrl_if #(.NUM_PHASES(3)) if3 ();
    traffic_phase_ctrl_if #(.NUM_PHASES(2)) if1 ();

    traffic_phase_ctrl #(.NUM_PHASES(2)) u2 (
        .CK(CK), .CLRN(rst2), .ctrl_io(if2.slave)
    );
    traffic_phase_ctrl #(.NUM_PHASES(3)) u3 (
        .CK(CK), .CLRN(rst3), .ctrl_io(if3.slave)
    );
    traffic_phase_ctrl #(
        .NUM_PHASES(2), .GREEN_TICKS(1), .YELLOW_TICKS(1), .ALLRED_TICKS(1)
    ) u1 (
        .CK(CK), .CLRN(rst1), .ctrl_io(if1.slave)
    );

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Kind: 0 all-red, 1 green, 2 yellow; kr = kind before the current red run (3 = reset)
    int k2p = 0, k2r = 3, k3p = 0, k3r = 3, k1p = 0, k1r = 3;

    always @(negedge CK) begin : mon2
        int cur;
        if (!rst2) begin
            k2p <= 0;
            k2r <= 3;
        end else begin
            cur = (if2.GRN != 0) ? 1 : (if2.YLW != 0) ? 2 : 0;
            n_cmp++;
            if ($countones(if2.GRN | if2.YLW) > 1 || if2.RED !== ~(if2.GRN | if2.YLW)) begin
                n_bad++;
                $display("FAIL lamp_inv u2 t=%0t: grn=%b ylw=%b red=%b", $time, if2.GRN, if2.YLW, if2.RED);
            end
            n_cmp++;
            if (cur == 1 && (k2p == 2 || (k2p == 0 && k2r != 2 && k2r != 3))) begin
                n_bad++;
                $display("FAIL green_order u2 t=%0t: prev=%0d before_red=%0d, want yellow then red", $time, k2p, k2r);
            end
            if (cur == 0 && k2p != 0) k2r <= k2p;
            k2p <= cur;
        end
    end

    always @(negedge CK) begin : mon3
        int cur;
        if (!rst3) begin
            k3p <= 0;
            k3r <= 3;
        end else begin
            cur = (if3.GRN != 0) ? 1 : (if3.YLW != 0) ? 2 : 0;
            n_cmp++;
            if ($countones(if3.GRN | if3.YLW) > 1 || if3.RED !== ~(if3.GRN | if3.YLW)) begin
                n_bad++;
                $display("FAIL lamp_inv u3 t=%0t: grn=%b ylw=%b red=%b", $time, if3.GRN, if3.YLW, if3.RED);
            end
            n_cmp++;
            if (cur == 1 && (k3p == 2 || (k3p == 0 && k3r != 2 && k3r != 3))) begin
                n_bad++;
                $display("FAIL green_order u3 t=%0t: prev=%0d before_red=%0d, want yellow then red", $time, k3p, k3r);
            end
            if (cur == 0 && k3p != 0) k3r <= k3p;
            k3p <= cur;
        end
    end

    always @(negedge CK) begin : mon1
        int cur;
        if (!rst1) begin
            k1p <= 0;
            k1r <= 3;
        end else begin
            cur = (if1.GRN != 0) ? 1 : (if1.YLW != 0) ? 2 : 0;
            n_cmp++;
            if ($countones(if1.GRN | if1.YLW) > 1 || if1.RED !== ~(if1.GRN | if1.YLW)) begin
                n_bad++;
                $display("FAIL lamp_inv u1 t=%0t: grn=%b ylw=%b red=%b", $time, if1.GRN, if1.YLW, if1.RED);
            end
            n_cmp++;
            if (cur == 1 && (k1p == 2 || (k1p == 0 && k1r != 2 && k1r != 3))) begin
                n_bad++;
                $display("FAIL green_order u1 t=%0t: prev=%0d before_red=%0d, want yellow then red", $time, k1p, k1r);
            end
            if (cur == 0 && k1p != 0) k1r <= k1p;
            k1p <= cur;
        end
    end

    task automatic test_reset();
        n_cmp++;
        if (if2.GRN !== 2'b00 || if2.YLW !== 2'b00 || if2.RED !== 2'b11 || if2.PHASE !== 1'b1) begin
            n_bad++;
            $display("FAIL reset u2: grn=%b ylw=%b red=%b ph=%0d, want 00 00 11 1", if2.GRN, if2.YLW, if2.RED, if2.PHASE);
        end
        n_cmp++;
        if (if3.GRN !== 3'b000 || if3.YLW !== 3'b000 || if3.RED !== 3'b111 || if3.PHASE !== 2'd2) begin
            n_bad++;
            $display("FAIL reset u3: grn=%b ylw=%b red=%b ph=%0d, want 000 000 111 2", if3.GRN, if3.YLW, if3.RED, if3.PHASE);
        end
        n_cmp++;
        if (u2.dem_q !== 2'b00 || u3.dem_q !== 3'b000) begin
            n_bad++;
            $display("FAIL reset dem: u2=%b u3=%b, want 0", u2.dem_q, u3.dem_q);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] eg [8];
        logic [1:0] ey [8];
        logic [0:0] ep [8];
        int         en [8];
        eg = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        ey = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        ep = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        en = '{2, 40, 4, 2, 40, 4, 2, 1};
        if2.FM   = 1'b0;
        if2.TEST = 1'b1;
        rst2     = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < en[s]; c++) begin
                n_cmp++;
                if (if2.GRN !== eg[s] || if2.YLW !== ey[s] || if2.PHASE !== ep[s]) begin
                    n_bad++;
                    $display("FAIL seq seg%0d cyc%0d: grn=%b ylw=%b ph=%0d, want %b %b %0d",
                             s, c, if2.GRN, if2.YLW, if2.PHASE, eg[s], ey[s], ep[s]);
                end
                step();
            end
        end
    endtask

    task automatic test_prescaler();
        logic [1:0] eg [9];
        logic [1:0] ey [9];
        logic [0:0] ep [9];
        int         en [9];
        eg = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
        ey = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        ep = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        en = '{32, 640, 64, 32, 100, 34, 4, 2, 1};
        rst2 = 1'b0;
        step();
        if2.FM   = 1'b0;
        if2.TEST = 1'b0;
        rst2     = 1'b1;
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < en[s]; c++) begin
                if (s == 5 && c == 0) if2.TEST = 1'b1;
                n_cmp++;
                if (if2.GRN !== eg[s] || if2.YLW !== ey[s] || if2.PHASE !== ep[s]) begin
                    n_bad++;
                    $display("FAIL presc seg%0d cyc%0d: grn=%b ylw=%b ph=%0d, want %b %b %0d",
                             s, c, if2.GRN, if2.YLW, if2.PHASE, eg[s], ey[s], ep[s]);
                end
                step();
            end
        end
    endtask

    task automatic test_farm_skip();
        logic [2:0] eg [6];
        logic [2:0] ey [6];
        logic [1:0] ep [6];
        int         en [6];
        eg = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100};
        ey = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        ep = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
        en = '{2, 500, 19, 4, 2, 1};
        if3.FM     = 1'b1;
        if3.TEST   = 1'b1;
        if3.DEMAND = 3'b000;
        rst3       = 1'b1;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < en[s]; c++) begin
                if (s == 2 && c == 0) begin
                    if3.DEMAND = 3'b100;
                    step();
                    if3.DEMAND = 3'b000;
                    n_cmp++;
                    if (u3.dem_q !== 3'b100) begin
                        n_bad++;
                        $display("FAIL farm latch_set: dem=%b, want 100", u3.dem_q);
                    end
                end
                n_cmp++;
                if (if3.GRN !== eg[s] || if3.YLW !== ey[s] || if3.PHASE !== ep[s]) begin
                    n_bad++;
                    $display("FAIL farm seg%0d cyc%0d: grn=%b ylw=%b ph=%0d, want %b %b %0d",
                             s, c, if3.GRN, if3.YLW, if3.PHASE, eg[s], ey[s], ep[s]);
                end
                step();
            end
        end
        n_cmp++;
        if (u3.dem_q !== 3'b000 || if3.GRN !== 3'b100) begin
            n_bad++;
            $display("FAIL farm latch_clr: dem=%b grn=%b, want 000 100", u3.dem_q, if3.GRN);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] eg [8];
        logic [1:0] ey [8];
        logic [0:0] ep [8];
        int         en [8];
        eg = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        ey = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        ep = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        en = '{2, 40, 4, 2, 40, 4, 2, 1};
        rst2 = 1'b0;
        step();
        if2.FM   = 1'b0;
        if2.TEST = 1'b1;
        rst2     = 1'b1;
        repeat (12) step();
        n_cmp++;
        if (if2.GRN !== 2'b01) begin
            n_bad++;
            $display("FAIL areset pre: grn=%b, want 01", if2.GRN);
        end
        #2;
        rst2 = 1'b0;
        #1;
        n_cmp++;
        if (if2.GRN !== 2'b00 || if2.YLW !== 2'b00 || if2.RED !== 2'b11 || if2.PHASE !== 1'b1) begin
            n_bad++;
            $display("FAIL areset now: grn=%b ylw=%b red=%b ph=%0d, want 00 00 11 1", if2.GRN, if2.YLW, if2.RED, if2.PHASE);
        end
        step();
        rst2 = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < en[s]; c++) begin
                n_cmp++;
                if (if2.GRN !== eg[s] || if2.YLW !== ey[s] || if2.PHASE !== ep[s]) begin
                    n_bad++;
                    $display("FAIL areset seg%0d cyc%0d: grn=%b ylw=%b ph=%0d, want %b %b %0d",
                             s, c, if2.GRN, if2.YLW, if2.PHASE, eg[s], ey[s], ep[s]);
                end
                step();
            end
        end
    endtask

    task automatic test_farm_release();
        logic [1:0] eg [5];
        logic [1:0] ey [5];
        logic [0:0] ep [5];
        int         en [5];
        eg = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        ey = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        ep = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        en = '{2, 100, 20, 4, 2};
        rst2 = 1'b0;
        step();
        if2.FM     = 1'b1;
        if2.TEST   = 1'b1;
        if2.DEMAND = 2'b00;
        rst2       = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < en[s]; c++) begin
                if (s == 2 && c == 0) if2.FM = 1'b0;
                n_cmp++;
                if (if2.GRN !== eg[s] || if2.YLW !== ey[s] || if2.PHASE !== ep[s]) begin
                    n_bad++;
                    $display("FAIL release seg%0d cyc%0d: grn=%b ylw=%b ph=%0d, want %b %b %0d",
                             s, c, if2.GRN, if2.YLW, if2.PHASE, eg[s], ey[s], ep[s]);
                end
                if (s == 4 && c == 1) if2.DEMAND = 2'b11;
                step();
            end
        end
        if2.DEMAND = 2'b00;
        n_cmp++;
        if (if2.GRN !== 2'b10 || if2.PHASE !== 1'b1) begin
            n_bad++;
            $display("FAIL release green1: grn=%b ph=%0d, want 10 1", if2.GRN, if2.PHASE);
        end
        n_cmp++;
        if (u2.dem_q !== 2'b01) begin
            n_bad++;
            $display("FAIL release clr_wins: dem=%b, want 01", u2.dem_q);
        end
    endtask

    task automatic test_min_ticks();
        logic [1:0] eg [6];
        logic [1:0] ey [6];
        logic [0:0] ep [6];
        eg = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        ey = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
        ep = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        if1.FM     = 1'b0;
        if1.TEST   = 1'b1;
        if1.DEMAND = 2'b00;
        rst1       = 1'b1;
        n_cmp++;
        if (if1.GRN !== 2'b00 || if1.YLW !== 2'b00 || if1.PHASE !== 1'b1) begin
            n_bad++;
            $display("FAIL min first: grn=%b ylw=%b ph=%0d, want 00 00 1", if1.GRN, if1.YLW, if1.PHASE);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (if1.GRN !== eg[i % 6] || if1.YLW !== ey[i % 6] || if1.PHASE !== ep[i % 6]) begin
                n_bad++;
                $display("FAIL min cyc%0d: grn=%b ylw=%b ph=%0d, want %b %b %0d",
                         i, if1.GRN, if1.YLW, if1.PHASE, eg[i % 6], ey[i % 6], ep[i % 6]);
            end
        end
    endtask

    initial begin
        rst2 = 1'b0;
        rst3 = 1'b0;
        rst1 = 1'b0;
        if2.FM = 1'b0; if2.TEST = 1'b1; if2.DEMAND = 2'b00;
        if3.FM = 1'b0; if3.TEST = 1'b1; if3.DEMAND = 3'b000;
        if1.FM = 1'b0; if1.TEST = 1'b1; if1.DEMAND = 2'b00;
        repeat (3) step();
        test_reset();
        test_sequence();
        test_prescaler();
        test_farm_skip();
        test_async_reset();
        test_farm_release();
        test_min_ticks();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
